// File: rtl/svc_sim_lifecycle.sv
// svc_sim_lifecycle: simulation lifecycle controller.
// Sequences the CPU reset release and runs a watchdog. It captures the
// program exit code, then drains the UART before declaring completion.
// Finally it freezes the CPU and reports pass, fail or timeout.
// Optional feature macro: SVC_SIM_HEARTBEAT_EN. When defined, each retire
// pulse clears the watchdog, so it becomes an inactivity timeout.
module svc_sim_lifecycle #(
  parameter int RESET_CYCLES    = 16,
  parameter int WATCHDOG_CYCLES = 2_000_000,
  parameter int DRAIN_CYCLES    = 100_000,
  parameter int CW              = $clog2(WATCHDOG_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exit_valid,
  input  logic [7:0]    exit_code,
  input  logic          uart_busy,
  input  logic          retire,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [7:0]    code,
  output logic [CW-1:0] cycles
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES);
  localparam logic [CW-1:0] WD_LAST    = CW'(WATCHDOG_CYCLES - 1);
  localparam logic [CW-1:0] CYC_MAX    = CW'(WATCHDOG_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_FIN   = 3'd3,
    S_TOUT  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [CW-1:0] wd_cnt, wd_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic [CW-1:0] cycles_nxt;
  logic [7:0]    code_nxt;
  logic          done_nxt, pass_nxt, timeout_nxt, cpu_rst_nxt;

`ifndef SVC_SIM_HEARTBEAT_EN
  // The watchdog is an absolute limit here, so the retire pulse is not needed.
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      wd_cnt    <= '0;
      drain_cnt <= '0;
      cycles    <= '0;
      code      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      wd_cnt    <= wd_nxt;
      drain_cnt <= drain_nxt;
      cycles    <= cycles_nxt;
      code      <= code_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      timeout   <= timeout_nxt;
      cpu_rst_n <= cpu_rst_nxt;
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    wd_nxt      = wd_cnt;
    drain_nxt   = drain_cnt;
    cycles_nxt  = cycles;
    code_nxt    = code;
    done_nxt    = done;
    pass_nxt    = pass;
    timeout_nxt = timeout;
    cpu_rst_nxt = cpu_rst_n;

    case (state)
      S_HOLD: begin
        // The CPU reset is released once RESET_CYCLES edges have elapsed in HOLD.
        if (hold_cnt == HOLD_LAST) begin
          state_nxt   = S_RUN;
          cpu_rst_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      S_RUN: begin
        cycles_nxt = (cycles == CYC_MAX) ? cycles : cycles + 1'b1;
        wd_nxt     = (wd_cnt == WD_LAST) ? wd_cnt : wd_cnt + 1'b1;
        // The exit check comes first so that it wins a tie with watchdog expiry.
        if (exit_valid) begin
          code_nxt  = exit_code;
          drain_nxt = '0;
          state_nxt = S_DRAIN;
        end
`ifdef SVC_SIM_HEARTBEAT_EN
        else if (retire) begin
          wd_nxt = '0;
        end
`endif
        else if (wd_cnt == WD_LAST) begin
          state_nxt   = S_TOUT;
          done_nxt    = 1'b1;
          pass_nxt    = 1'b0;
          timeout_nxt = 1'b1;
          code_nxt    = 8'hFF;
          cpu_rst_nxt = 1'b0;
        end
      end

      S_DRAIN: begin
        // Wait for the UART to go idle, but never longer than DRAIN_CYCLES.
        if (!uart_busy || (drain_cnt == DRAIN_LAST)) begin
          state_nxt   = S_FIN;
          done_nxt    = 1'b1;
          pass_nxt    = (code == 8'h00);
          timeout_nxt = 1'b0;
          cpu_rst_nxt = 1'b0;
        end else begin
          drain_nxt = drain_cnt + 1'b1;
        end
      end

      S_FIN, S_TOUT: begin
        // Terminal states: everything is held until rst_n.
      end

      default: begin
        state_nxt = S_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_svc_sim_lifecycle.sv
// Directed testbench for svc_sim_lifecycle.
// u_a uses a long drain limit and u_b a short one (8); both share the stimulus.
module tb_svc_sim_lifecycle;

  localparam int RC = 4;
  localparam int WD = 50;
  localparam int CWB = $clog2(WD + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           exit_valid = 1'b0;
  logic [7:0]     exit_code = 8'h00;
  logic           uart_busy = 1'b0;
  logic           retire = 1'b0;

  logic           a_cpu_rst_n, a_done, a_pass, a_timeout;
  logic [7:0]     a_code;
  logic [CWB-1:0] a_cycles;
  logic           b_cpu_rst_n, b_done, b_pass, b_timeout;
  logic [7:0]     b_code;
  logic [CWB-1:0] b_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  svc_sim_lifecycle #(
    .RESET_CYCLES(RC), .WATCHDOG_CYCLES(WD), .DRAIN_CYCLES(32)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .exit_valid(exit_valid), .exit_code(exit_code),
    .uart_busy(uart_busy), .retire(retire), .cpu_rst_n(a_cpu_rst_n),
    .done(a_done), .pass(a_pass), .timeout(a_timeout), .code(a_code),
    .cycles(a_cycles)
  );

  svc_sim_lifecycle #(
    .RESET_CYCLES(RC), .WATCHDOG_CYCLES(WD), .DRAIN_CYCLES(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .exit_valid(exit_valid), .exit_code(exit_code),
    .uart_busy(uart_busy), .retire(retire), .cpu_rst_n(b_cpu_rst_n),
    .done(b_done), .pass(b_pass), .timeout(b_timeout), .code(b_code),
    .cycles(b_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asserts rst_n between edges, checks the asynchronous clear, then releases
  // it and checks that the CPU reset is held for RC edges and released on the next one.
  task automatic reset_and_release(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    exit_valid = 1'b0;
    uart_busy = 1'b0;
    retire = 1'b0;
    #2;
    chk({tag, "_rst_done"},    32'(a_done), 32'd0);
    chk({tag, "_rst_pass"},    32'(a_pass), 32'd0);
    chk({tag, "_rst_timeout"}, 32'(a_timeout), 32'd0);
    chk({tag, "_rst_code"},    32'(a_code), 32'd0);
    chk({tag, "_rst_cycles"},  32'(a_cycles), 32'd0);
    chk({tag, "_rst_cpu"},     32'(a_cpu_rst_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (RC) @(negedge clk);
    chk({tag, "_hold_cpu"}, 32'(a_cpu_rst_n), 32'd0);
    @(negedge clk);
    chk({tag, "_run_cpu"},  32'(a_cpu_rst_n), 32'd1);
    chk({tag, "_run_done"}, 32'(a_done), 32'd0);
  endtask

  initial begin
    // Exit code 0 with the UART busy for 10 drain cycles; u_b hits its drain limit.
    reset_and_release("t1");
    exit_valid = 1'b1; exit_code = 8'h00; uart_busy = 1'b1;
    @(negedge clk);
    exit_code = 8'h05;                  // a second strobe in DRAIN must be ignored
    chk("t2_code_cap", 32'(a_code), 32'h00);
    chk("t2_cycles_cap", 32'(a_cycles), 32'd1);
    @(negedge clk);
    exit_valid = 1'b0;
    chk("t2_drain_ignore", 32'(a_code), 32'h00);
    repeat (6) @(negedge clk);
    chk("t5_b_drain7", 32'(b_done), 32'd0);
    @(negedge clk);
    chk("t5_b_done", 32'(b_done), 32'd1);
    chk("t5_b_pass", 32'(b_pass), 32'd1);
    chk("t5_b_cpu",  32'(b_cpu_rst_n), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_drain10_done", 32'(a_done), 32'd0);
    chk("t2_drain10_cpu",  32'(a_cpu_rst_n), 32'd1);
    chk("t2_cycles_frozen", 32'(a_cycles), 32'd1);
    uart_busy = 1'b0;
    @(negedge clk);
    chk("t2_done", 32'(a_done), 32'd1);
    chk("t2_pass", 32'(a_pass), 32'd1);
    chk("t2_timeout", 32'(a_timeout), 32'd0);
    chk("t2_code", 32'(a_code), 32'h00);
    chk("t2_cpu", 32'(a_cpu_rst_n), 32'd0);
    exit_valid = 1'b1; exit_code = 8'h05;
    @(negedge clk);
    exit_valid = 1'b0;
    chk("t2_fin_sticky_code", 32'(a_code), 32'h00);
    chk("t2_fin_sticky_done", 32'(a_done), 32'd1);

    // Failing exit code with the UART idle.
    reset_and_release("t3");
    exit_valid = 1'b1; exit_code = 8'h03;
    @(negedge clk);
    exit_valid = 1'b0;
    chk("t3_code_cap", 32'(a_code), 32'h03);
    chk("t3_notdone",  32'(a_done), 32'd0);
    @(negedge clk);
    chk("t3_done", 32'(a_done), 32'd1);
    chk("t3_pass", 32'(a_pass), 32'd0);
    chk("t3_timeout", 32'(a_timeout), 32'd0);
    chk("t3_code", 32'(a_code), 32'h03);
    chk("t3_cpu", 32'(a_cpu_rst_n), 32'd0);

    // Watchdog behaviour with retire pulses every 20 cycles.
    reset_and_release("t4");
`ifdef SVC_SIM_HEARTBEAT_EN
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      retire = ((i % 20) == 0);
    end
    retire = 1'b0;
    chk("t4_hb_notdone", 32'(a_done), 32'd0);
    chk("t4_hb_timeout", 32'(a_timeout), 32'd0);
    chk("t4_hb_cycles_sat", 32'(a_cycles), 32'(WD));
    chk("t4_hb_cpu", 32'(a_cpu_rst_n), 32'd1);
`else
    for (int i = 1; i <= WD - 1; i++) begin
      @(negedge clk);
      retire = ((i % 20) == 0);
    end
    retire = 1'b0;
    chk("t4_pre_done", 32'(a_done), 32'd0);
    chk("t4_pre_cycles", 32'(a_cycles), 32'(WD - 1));
    @(negedge clk);
    chk("t4_done", 32'(a_done), 32'd1);
    chk("t4_timeout", 32'(a_timeout), 32'd1);
    chk("t4_pass", 32'(a_pass), 32'd0);
    chk("t4_code", 32'(a_code), 32'hFF);
    chk("t4_cycles", 32'(a_cycles), 32'(WD));
    chk("t4_cpu", 32'(a_cpu_rst_n), 32'd0);
`endif

    // The exit strobe lands on the watchdog expiry edge, and exit wins.
    reset_and_release("t5");
    repeat (WD - 1) @(negedge clk);
    exit_valid = 1'b1; exit_code = 8'h07;
    @(negedge clk);
    exit_valid = 1'b0;
    chk("t5_tie_timeout", 32'(a_timeout), 32'd0);
    chk("t5_tie_code", 32'(a_code), 32'h07);
    chk("t5_tie_cycles", 32'(a_cycles), 32'(WD));
    @(negedge clk);
    chk("t5_tie_done", 32'(a_done), 32'd1);
    chk("t5_tie_timeout2", 32'(a_timeout), 32'd0);
    chk("t5_tie_pass", 32'(a_pass), 32'd0);

    // Reset asserted in the middle of DRAIN, followed by a normal passing run.
    reset_and_release("t6a");
    exit_valid = 1'b1; exit_code = 8'h09; uart_busy = 1'b1;
    @(negedge clk);
    exit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_drain_code", 32'(a_code), 32'h09);
    chk("t6_drain_done", 32'(a_done), 32'd0);
    reset_and_release("t6b");
    exit_valid = 1'b1; exit_code = 8'h00;
    @(negedge clk);
    exit_valid = 1'b0;
    @(negedge clk);
    chk("t6_done", 32'(a_done), 32'd1);
    chk("t6_pass", 32'(a_pass), 32'd1);
    chk("t6_code", 32'(a_code), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/svc_sim_lifecycle.md
# svc_sim_lifecycle

Lifecycle controller for the interactive SoC simulation harness. It sequences the CPU reset release and runs the watchdog. It catches the program's exit write and drains the UART before declaring completion. It then freezes the CPU and reports pass, fail or timeout to the bench. It sits between the testbench clock/reset source and the CPU/peripheral reset tree. It observes the CPU's exit MMIO strobe and the UART transmitter's busy flag.

## Interface
- RESET_CYCLES, 16: cycles `cpu_rst_n` is held low after `rst_n` deasserts (must be ≥1).
- WATCHDOG_CYCLES, 2_000_000: cycle budget in RUN before timeout (must be ≥2).
- DRAIN_CYCLES, 100_000: maximum cycles spent waiting for the UART to go idle after exit.
- CW, $clog2(WATCHDOG_CYCLES+1): width of the watchdog and cycle counters.

Ports:
- clk  in  1  simulation clock.
- rst_n  in  1  asynchronous, active-low reset.
- exit_valid  in  1  single-cycle strobe: the CPU wrote the exit register.
- exit_code  in  8  value written with `exit_valid`; 0 means pass.
- uart_busy  in  1  UART TX shift register or FIFO is non-empty.
- retire  in  1  instruction-retired pulse; used only when SVC_SIM_HEARTBEAT_EN is defined.
- cpu_rst_n  out  1  registered active-low reset to the CPU and peripherals.
- done  out  1  sticky; the run has terminated.
- pass  out  1  valid when `done`; exit code was 0.
- timeout  out  1  valid when `done`; the watchdog expired.
- code  out  8  captured exit code; 8'hFF on timeout.
- cycles  out  CW  RUN cycle count, frozen at termination.

## Operation
- States: HOLD → RUN → DRAIN → FIN, plus RUN → TOUT.
- HOLD: `cpu_rst_n`=0 and a counter runs. After RESET_CYCLES cycles in HOLD, go to RUN.
- RUN: `cpu_rst_n`=1. `cycles` and the watchdog increment every cycle.
  - On `exit_valid`, capture `exit_code` into `code` and go to DRAIN.
  - Otherwise, when the watchdog equals WATCHDOG_CYCLES-1, go to TOUT.
  - `exit_valid` and expiry in the same cycle: exit wins, so the next state is DRAIN.
- DRAIN: `cpu_rst_n` stays 1 so the UART can finish. `exit_valid` is ignored, and `cycles` is frozen.
  - Go to FIN on the first cycle `uart_busy`=0.
  - Also go to FIN when the drain counter reaches DRAIN_CYCLES-1, even if the UART is still busy.
- FIN: `done`=1, `pass`=(`code`==0), `timeout`=0, `cpu_rst_n`=0. The block stays in FIN until `rst_n`.
- TOUT: `done`=1, `pass`=0, `timeout`=1, `code`=8'hFF, `cpu_rst_n`=0. The block stays in TOUT until `rst_n`.
- Counter widths: counters saturate and never wrap. `cycles` stops at WATCHDOG_CYCLES.
- `exit_valid` is ignored in HOLD, DRAIN, FIN and TOUT.

## Timing
- On async assertion of `rst_n`, the following take effect immediately:
  - state = HOLD
  - `cpu_rst_n`=0, `done`=0, `pass`=0, `timeout`=0
  - `code`=0, `cycles`=0
  - all counters cleared
- `cpu_rst_n` rises on the clock edge RESET_CYCLES cycles after the first rising edge with `rst_n`=1.
- Exit capture: with `exit_valid` at edge N, `code` is valid after edge N and the state is DRAIN.
  - If `uart_busy`=0 at edge N+1, `done` and `pass` are valid after edge N+1.
  - `cpu_rst_n` falls at the same edge as `done`.
- Timeout: `done`/`timeout` assert exactly WATCHDOG_CYCLES edges after entering RUN when no exit occurs. At that point `cycles`=WATCHDOG_CYCLES.
- All outputs are registered, with no combinational input-to-output paths.
- Reset mid-operation: any state returns to HOLD asynchronously, and the full HOLD sequence repeats.

## Configuration
- SVC_SIM_HEARTBEAT_EN defined: the watchdog clears on every `retire` pulse in RUN, making it an inactivity timeout. `cycles` still counts all RUN cycles.
- SVC_SIM_HEARTBEAT_EN undefined: `retire` is unused, and the watchdog is an absolute cycle limit equal to `cycles`.

## Test plan
- Reset release, RESET_CYCLES=4 → `cpu_rst_n` stays 0 for 4 edges after `rst_n` rises, then 1; `done`=0.
- `exit_valid` with `exit_code`=0 while `uart_busy`=1 for 10 cycles → DRAIN for 10 cycles. Next edge: `done`=1, `pass`=1, `code`=0, `cpu_rst_n`=0.
- `exit_valid` with `exit_code`=3 and `uart_busy`=0 → `done`=1, `pass`=0, `timeout`=0, `code`=3 one cycle after capture.
- WATCHDOG_CYCLES=50, no exit → `timeout`=1 and `code`=8'hFF after exactly 50 RUN cycles, `cycles`=50. With SVC_SIM_HEARTBEAT_EN and `retire` every 20 cycles → no timeout after 200 cycles.
- `exit_valid` on the same cycle as watchdog expiry → DRAIN path and `timeout`=0. Separately, `uart_busy` stuck at 1 with DRAIN_CYCLES=8 → FIN after 8 cycles.
- `rst_n` asserted mid-DRAIN → all outputs clear immediately. A subsequent normal run passes.
